// File: rtl/rll_key_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rll_key_sequencer                                              |
// | Purpose : Loads a serial unlock key with a nibble-XOR checksum, commits  |
// |           it to the keyIn bus of a logic-locked combinational core, and  |
// |           then runs valid/ready patterns through that core, capturing    |
// |           its outputs SETTLE cycles after each input update.             |
// | Ports   : clk, rst (async, active-high)                                  |
// |           key_sdi/key_sdi_valid  - serial key frame in, MSB first        |
// |           key_done/key_err       - one-cycle commit / mismatch pulses    |
// |           key_ok, key_out        - applied-key status and keyIn drive    |
// |           in_valid/in_ready/in_data    - pattern handshake               |
// |           core_in / core_out           - drive to / result from core     |
// |           out_valid/out_ready/out_data - result handshake                |
// |           busy                   - state outside IDLE and READY          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module rll_key_sequencer #(
  parameter int KEY_W  = 16,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sdi,
  input  logic             key_sdi_valid,
  output logic             key_done,
  output logic             key_err,
  output logic             key_ok,
  output logic [KEY_W-1:0] key_out,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  // Frame = key bits followed by the 4-bit checksum.
  localparam int FRAME_W = KEY_W + 4;
  // One counter serves both the frame bit count and the settle countdown.
  localparam int CNT_W   = $clog2(FRAME_W + SETTLE + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT    = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_INIT = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_READY = 3'd3,
    S_WAIT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_W-1:0]   r_shift;
  logic [KEY_W-1:0]     r_key_out;
  logic                 r_key_ok;
  logic                 r_key_done;
  logic                 r_key_err;
  logic [IN_W-1:0]      r_core_in;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [3:0]           w_sum;
  logic                 w_key_match;
  logic                 w_shift_en;
  logic                 w_accept;
  logic                 w_in_ready;

  // Checksum of the key portion of the shift register (bits above the nibble).
  always_comb begin
    w_sum = 4'h0;
    for (int i = 0; i < KEY_W / 4; i++) begin
      w_sum = w_sum ^ r_shift[4 + 4*i +: 4];
    end
  end
  assign w_key_match = (w_sum == r_shift[3:0]);

  // Key bits are only taken where a load can start or continue; anywhere
  // else (CHECK, WAIT, HOLD) they are dropped.
  assign w_shift_en = key_sdi_valid &&
                      (r_state == S_IDLE || r_state == S_LOAD || r_state == S_READY);
  // A key bit in READY wins over a pattern.
  assign w_in_ready = (r_state == S_READY) && !key_sdi_valid;
  assign w_accept   = w_in_ready && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (key_sdi_valid) w_state_nxt = S_LOAD;
      S_LOAD:  if (key_sdi_valid && r_cnt == C_LAST_BIT) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_key_match ? S_READY : S_IDLE;
      S_READY: begin
        if (key_sdi_valid)  w_state_nxt = S_LOAD;
        else if (in_valid)  w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (r_cnt == '0) w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_READY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_key_out   <= '0;
      r_key_ok    <= 1'b0;
      r_key_done  <= 1'b0;
      r_key_err   <= 1'b0;
      r_core_in   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_key_done <= 1'b0;
      r_key_err  <= 1'b0;
      r_busy     <= !(w_state_nxt == S_IDLE || w_state_nxt == S_READY);

      if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_W-2:0], key_sdi};
      end

      case (r_state)
        S_IDLE: begin
          if (key_sdi_valid) r_cnt <= C_CNT_ONE;
        end
        S_LOAD: begin
          if (key_sdi_valid) begin
            // Clear on the last bit so READY is always entered with a zero count.
            r_cnt <= (r_cnt == C_LAST_BIT) ? '0 : r_cnt + C_CNT_ONE;
          end
        end
        S_CHECK: begin
          if (w_key_match) begin
            r_key_out  <= r_shift[FRAME_W-1:4];
            r_key_ok   <= 1'b1;
            r_key_done <= 1'b1;
          end else begin
            r_key_err  <= 1'b1;
          end
        end
        S_READY: begin
          if (key_sdi_valid) begin
            // Reload: the old key stays on the bus but is no longer trusted.
            r_cnt    <= C_CNT_ONE;
            r_key_ok <= 1'b0;
          end else if (in_valid) begin
            r_core_in <= in_data;
            r_cnt     <= C_SETTLE_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_out_data  <= core_out;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        S_HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign key_done  = r_key_done;
  assign key_err   = r_key_err;
  assign key_ok    = r_key_ok;
  assign key_out   = r_key_out;
  assign in_ready  = w_in_ready;
  assign core_in   = r_core_in;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

  // w_accept documents the READY accept condition used by the FSM above.
  logic w_unused;
  assign w_unused = w_accept;

endmodule
`default_nettype wire

// File: tb/tb_rll_key_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rll_key_sequencer                                           |
// | Purpose : Directed self-checking bench for rll_key_sequencer. A core     |
// |           model (core_out = core_in ^ core_mask) feeds the DUT and a     |
// |           scoreboard queue holds the expected captured results.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rll_key_sequencer;

  localparam int KEY_W  = 16;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 32;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_sdi = 1'b0;
  logic             key_sdi_valid = 1'b0;
  logic             key_done, key_err, key_ok;
  logic [KEY_W-1:0] key_out;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic [IN_W-1:0]  core_in;
  logic [OUT_W-1:0] core_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             busy;
  logic [OUT_W-1:0] core_mask = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [OUT_W-1:0] sb[$];

  always #5 clk = ~clk;

  // Locked-core stand-in.
  assign core_out = core_in ^ core_mask;

  rll_key_sequencer #(
    .KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .key_sdi(key_sdi), .key_sdi_valid(key_sdi_valid),
    .key_done(key_done), .key_err(key_err), .key_ok(key_ok), .key_out(key_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_in(core_in), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts {key, cs} MSB first. stall_at inserts one idle cycle before that
  // bit index (use -1 for none). On a reload, the first bit is sent together
  // with in_valid and the key status right after it is checked.
  task automatic send_frame(input logic [15:0] key, input logic [3:0] cs,
                            input int stall_at, input logic reload,
                            input logic [15:0] prev_key);
    logic [19:0] frame;
    frame = {key, cs};
    for (int i = 19; i >= 0; i--) begin
      if (i == stall_at) begin
        key_sdi_valid = 1'b0;
        tick();
      end
      key_sdi_valid = 1'b1;
      key_sdi = frame[i];
      if (reload && i == 19) in_valid = 1'b1;
      #1;
      chk("in_ready_during_key_bit", in_ready, 1'b0);
      tick();
      if (reload && i == 19) begin
        in_valid = 1'b0;
        chk("reload_key_ok_cleared", key_ok, 1'b0);
        chk("reload_key_out_held", key_out, prev_key);
        chk("reload_busy", busy, 1'b1);
      end
    end
    key_sdi_valid = 1'b0;
  endtask

  // Accept one pattern, check SETTLE latency, stall out_ready for `hold`
  // cycles, then complete the handshake.
  task automatic run_pattern(input logic [31:0] data, input logic [31:0] mask, input int hold);
    logic [31:0] exp;
    core_mask = mask;
    in_data   = data;
    in_valid  = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    sb.push_back(data ^ mask);
    tick();                                   // edge T
    in_valid = 1'b0;
    chk("core_in_after_accept", core_in, data);
    chk("busy_in_wait", busy, 1'b1);
    chk("out_valid_T", out_valid, 1'b0);
    tick();                                   // edge T+1
    chk("out_valid_T1", out_valid, 1'b0);
    tick();                                   // edge T+2: capture
    chk("out_valid_T2", out_valid, 1'b1);
    exp = sb.pop_front();
    chk("out_data_capture", out_data, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("out_valid_stalled", out_valid, 1'b1);
      chk("out_data_stalled", out_data, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 1'b0);
    chk("in_ready_after_hs", in_ready, 1'b1);
    chk("out_data_held", out_data, exp);
    chk("core_in_held", core_in, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    in_valid = 1'b1;
    repeat (2) tick();
    chk("rst_key_out", key_out, 16'h0);
    chk("rst_key_ok", key_ok, 1'b0);
    chk("rst_key_done", key_done, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    chk("rst_core_in", core_in, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Bad checksum from reset.
    send_frame(16'h1234, 4'h5, -1, 1'b0, 16'h0);
    chk("bad_err_early", key_err, 1'b0);
    chk("bad_busy_check", busy, 1'b1);
    tick();
    chk("bad_key_err", key_err, 1'b1);
    chk("bad_key_done", key_done, 1'b0);
    chk("bad_key_ok", key_ok, 1'b0);
    chk("bad_key_out", key_out, 16'h0);
    chk("bad_busy_idle", busy, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("bad_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("bad_err_pulse_end", key_err, 1'b0);
    chk("bad_no_accept", core_in, 32'h0);

    // Good key: last bit at edge E, commit at E+1.
    send_frame(16'h1234, 4'h4, -1, 1'b0, 16'h0);
    chk("good_done_early", key_done, 1'b0);
    chk("good_key_ok_early", key_ok, 1'b0);
    tick();
    chk("good_key_done", key_done, 1'b1);
    chk("good_key_err", key_err, 1'b0);
    chk("good_key_ok", key_ok, 1'b1);
    chk("good_key_out", key_out, 16'h1234);
    chk("good_in_ready", in_ready, 1'b1);
    chk("good_busy", busy, 1'b0);
    tick();
    chk("good_done_pulse_end", key_done, 1'b0);

    // Patterns: stalled result, then back-to-back.
    run_pattern(32'hDEADBEEF, 32'hD1A2B1E0, 3);
    run_pattern(32'h12345678, 32'hFFFF0000, 0);

    // Key bits during WAIT and HOLD are dropped.
    core_mask = 32'h0000FFFF;
    in_data   = 32'h0BADF00D;
    in_valid  = 1'b1;
    sb.push_back(32'h0BADF00D ^ 32'h0000FFFF);
    tick();                                   // accept
    in_valid = 1'b0;
    key_sdi_valid = 1'b1;
    key_sdi = 1'b1;
    tick();                                   // WAIT
    tick();                                   // capture
    tick();                                   // HOLD
    chk("ign_out_valid", out_valid, 1'b1);
    chk("ign_out_data", out_data, sb.pop_front());
    chk("ign_key_ok", key_ok, 1'b1);
    key_sdi_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ign_ready_again", in_ready, 1'b1);
    chk("ign_key_out", key_out, 16'h1234);
    chk("ign_busy", busy, 1'b0);

    // Reload from READY with a stall; a wrong leftover count would shift
    // the commit cycle. Checksum of A5C3 = A^5^C^3 = 0.
    send_frame(16'hA5C3, 4'h0, 9, 1'b1, 16'h1234);
    chk("reload_no_accept", core_in, 32'h0BADF00D);
    chk("reload_done_early", key_done, 1'b0);
    chk("reload_key_out_pre", key_out, 16'h1234);
    tick();
    chk("reload_key_done", key_done, 1'b1);
    chk("reload_key_out", key_out, 16'hA5C3);
    chk("reload_key_ok", key_ok, 1'b1);

    // Asynchronous reset in WAIT.
    in_data  = 32'hCAFEF00D;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_core_in", core_in, 32'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_key_out", key_out, 16'h0);
    chk("arst_key_ok", key_ok, 1'b0);
    chk("arst_core_in", core_in, 32'h0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, 32'h0);
    chk("arst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    in_data  = 32'h55AA55AA;
    in_valid = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_core_in", core_in, 32'h0);
    chk("post_rst_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rll_key_sequencer.md
# rll_key_sequencer

Sequential controller that loads, checks and applies the 16-bit unlock key of a random-logic-locked combinational core, then runs evaluation patterns through that core under a valid/ready handshake. It sits between a serial key source (tamper-proof storage or scan port) and the locked netlist. It drives the core's `keyIn` bus and primary inputs, and registers the core's primary outputs after a fixed settle time. No pattern reaches the core until a key with a correct checksum has been committed.

## Interface
- `KEY_W`, 16, key width; multiple of 4
- `IN_W`, 32, core primary-input width
- `OUT_W`, 32, core primary-output width
- `SETTLE`, 2, cycles from core input update to output capture; ≥1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `key_sdi`  in  1  serial key bit, MSB first
- `key_sdi_valid`  in  1  `key_sdi` is valid this cycle
- `key_done`  out  1  one-cycle pulse: key committed
- `key_err`  out  1  one-cycle pulse: checksum mismatch
- `key_ok`  out  1  level: valid key applied
- `key_out`  out  KEY_W  drives core keyIn bus
- `in_valid` / `in_ready`  in / out  1  pattern handshake
- `in_data`  in  IN_W  pattern
- `core_in`  out  IN_W  registered drive to core inputs
- `core_out`  in  OUT_W  core outputs (combinational)
- `out_valid` / `out_ready`  out / in  1  result handshake
- `out_data`  out  OUT_W  captured result
- `busy`  out  1  state ∉ {IDLE, READY}

## Operation
- Key frame: KEY_W key bits, then a 4-bit checksum, both MSB first. Checksum = XOR of all KEY_W/4 nibbles of the key.
- States: IDLE, LOAD, CHECK, READY, WAIT, HOLD.
- IDLE: `key_sdi_valid` = 1 → LOAD; the bit is shifted in and the counter is set to 1.
- LOAD: shift on each valid bit. After bit KEY_W+3 is accepted → CHECK. Cycles with `key_sdi_valid` = 0 are stalls.
- CHECK, one cycle:
  - Match: `key_out` ← shifted key, `key_ok` = 1, `key_done` pulse → READY.
  - Mismatch: `key_err` pulse, `key_ok` stays 0, `key_out` unchanged → IDLE.
- READY, new key bit: a `key_sdi_valid` bit starts a reload. Next state LOAD, `key_ok` ← 0, `key_out` holds its old value until the next commit.
- READY, pattern accept: `in_ready` = (state == READY) & !`key_sdi_valid`, so a key load has priority over a pattern. On accept, `core_in` ← `in_data`, counter ← SETTLE-1 → WAIT.
- WAIT: decrement each cycle. When the counter is 0, `out_data` ← `core_out`, `out_valid` ← 1 → HOLD.
- HOLD: when `out_valid` & `out_ready`, `out_valid` ← 0 → READY. `out_data` and `core_in` hold their values.
- `key_sdi_valid` in CHECK, WAIT or HOLD is ignored and those bits are dropped.
- `in_valid` is ignored outside READY.

## Timing
- Reset values: state IDLE; `key_out` = 0, `core_in` = 0, `out_data` = 0; `key_ok`, `key_done`, `key_err`, `out_valid`, `busy` all 0; bit counter 0; shift register 0.
- Reset mid-operation: everything above is restored and the key is lost. A new full frame is required.
- Key latency: last checksum bit sampled at edge E. CHECK occupies E..E+1. `key_out`, `key_ok` and `key_done` (or `key_err`) change at edge E+1. Pulses last exactly one cycle.
- Pattern latency: accept at edge T, `core_in` valid after T. Capture at edge T+SETTLE; `out_valid` high from T+SETTLE. Earliest next accept is the edge after the `out_ready` handshake, giving throughput of one pattern per SETTLE+2 cycles.
- `in_ready` is combinational from state and `key_sdi_valid`. All other outputs are registered.

## Test plan
- Reset, then shift key 0x1234 with checksum 0x4 (20 bits, no stalls) → `key_done` at edge 21, `key_out` = 0x1234, `key_ok` = 1, `in_ready` = 1.
- Shift 0x1234 with checksum 0x5 → `key_err` pulse, `key_ok` = 0, `key_out` = 0x0000 (prior value), state IDLE, `in_ready` = 0.
- With key_ok, SETTLE = 2, `in_data` = 0xDEADBEEF accepted at T → `core_in` = 0xDEADBEEF after T. Drive `core_out` = 0x0F0F0F0F → `out_valid` at T+2 with `out_data` = 0x0F0F0F0F. Hold `out_ready` = 0 for 3 cycles → `out_data` stable; release → `out_valid` 0, `in_ready` 1.
- In READY, assert `in_valid` and `key_sdi_valid` in the same cycle → `in_ready` = 0, LOAD entered, `key_ok` 0 next cycle, `key_out` unchanged until commit.
- Key bits pulsed during WAIT/HOLD → ignored; the bit counter stays 0 after returning to READY.
- Assert `rst` in WAIT after a valid key → all outputs reach their reset values asynchronously; an `in_valid` afterwards is not accepted.
